// File: rtl/regfile_pkg.sv
// Shared widths, the hardwired-zero register index and the writeback queue entry layout
// used across the register-file writeback slice.
package regfile_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int FIFO_DEPTH = 4;

  localparam logic [ADDR_WIDTH-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wbEntry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO holding accepted writeback results in arrival order.
// Push while full and pop while empty are ignored.
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic                     iPush,
  input  logic [WIDTH-1:0]         iData,
  input  logic                     iPop,
  output logic [WIDTH-1:0]         oData,
  output logic [$clog2(DEPTH):0]   oCount,
  output logic                     oFull,
  output logic                     oEmpty
);

  localparam int PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wrPtr;
  logic [PtrW-1:0]  rdPtr;
  logic             doPush;
  logic             doPop;

  always_comb begin
    oFull  = (oCount == FullCnt);
    oEmpty = (oCount == '0);
    doPush = iPush && !oFull;
    doPop  = iPop && !oEmpty;
    oData  = mem[rdPtr];
  end

  // Storage carries no reset; stale contents are never visible because oEmpty gates them.
  always_ff @(posedge iClk) begin
    if (doPush) mem[wrPtr] <= iData;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      oCount <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   oCount <= oCount + 1'b1;
        2'b01:   oCount <= oCount - 1'b1;
        default: oCount <= oCount;
      endcase
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// Writeback stage: arbitrates load/ALU results into an in-order queue, drains one write
// per cycle to the register file and tracks pending destinations for hazard detection.
module regfile_writeback
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
  parameter int FIFO_DEPTH = regfile_pkg::FIFO_DEPTH
) (
  input  logic                          iClk,
  input  logic                          iRst,
  input  logic                          iLdValid,
  input  logic [ADDR_WIDTH-1:0]         iLdAddr,
  input  logic [DATA_WIDTH-1:0]         iLdData,
  output logic                          oLdReady,
  input  logic                          iAluValid,
  input  logic [ADDR_WIDTH-1:0]         iAluAddr,
  input  logic [DATA_WIDTH-1:0]         iAluData,
  output logic                          oAluReady,
  input  logic                          iIssueEn,
  input  logic [ADDR_WIDTH-1:0]         iIssueAddr,
  input  logic [ADDR_WIDTH-1:0]         iAddrCheck0,
  input  logic [ADDR_WIDTH-1:0]         iAddrCheck1,
  output logic                          oBusy0,
  output logic                          oBusy1,
  output logic [ADDR_WIDTH-1:0]         oAddrWrite,
  output logic [DATA_WIDTH-1:0]         oDataWrite,
  output logic                          oEnWrite,
  output logic [$clog2(FIFO_DEPTH):0]   oCount
);

  localparam int NumRegs = 2 ** ADDR_WIDTH;

  wbEntry_t           enqEntry;
  wbEntry_t           headEntry;
  logic               full;
  logic               empty;
  logic               ldAcc;
  logic               aluAcc;
  logic               push;
  logic               pop;
  logic [NumRegs-1:0] busy;
  logic [NumRegs-1:0] busyNext;

  // Load has fixed priority; an r0 destination completes the handshake but is dropped.
  always_comb begin
    ldAcc         = iLdValid && !full;
    aluAcc        = iAluValid && !full && !iLdValid;
    enqEntry.addr = ldAcc ? iLdAddr : iAluAddr;
    enqEntry.data = ldAcc ? iLdData : iAluData;
    push          = (ldAcc || aluAcc) && (enqEntry.addr != REG_ZERO);
    pop           = !empty;
    oLdReady      = !full;
    oAluReady     = !full && !iLdValid;
  end

  wb_fifo #(
    .WIDTH ($bits(wbEntry_t)),
    .DEPTH (FIFO_DEPTH)
  ) uFifo (
    .iClk   (iClk),
    .iRst   (iRst),
    .iPush  (push),
    .iData  (enqEntry),
    .iPop   (pop),
    .oData  (headEntry),
    .oCount (oCount),
    .oFull  (full),
    .oEmpty (empty)
  );

  always_comb begin
    oEnWrite   = !empty;
    oAddrWrite = empty ? REG_ZERO : headEntry.addr;
    oDataWrite = empty ? '0 : headEntry.data;
  end

  // Clear for the popping head first so a same-edge re-issue of that register wins.
  always_comb begin
    busyNext = busy;
    if (pop) busyNext[headEntry.addr] = 1'b0;
    if (iIssueEn && (iIssueAddr != REG_ZERO)) busyNext[iIssueAddr] = 1'b1;
    busyNext[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) busy <= '0;
    else      busy <= busyNext;
  end

  always_comb begin
    oBusy0 = busy[iAddrCheck0] && (iAddrCheck0 != REG_ZERO);
    oBusy1 = busy[iAddrCheck1] && (iAddrCheck1 != REG_ZERO);
  end

endmodule
